uart_bus_peripheral: RTL and testbench

//  CPU-side UART device for the 8-bit CPU: the responder to the CPU's uart reads/writes.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo.sv | 52 +++++
 rtl/uart_bus_peripheral.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_bus_peripheral.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the CPU-side UART device.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = $clog2(DATA_BITS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a simultaneous push and pop are both
// honoured, so a full FIFO accepts a push in the same cycle it is popped.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;
  assign dout     = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty/full come from the pointers,
  // so stale entries are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_bus_peripheral.sv
// CPU-side UART: 8N1 receiver and transmitter behind RX/TX FIFOs, with the DI/DO
// poll flags and sticky framing/overrun errors seen by the 8-bit CPU.
module uart_bus_peripheral
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int RX_DEPTH     = 16,
  parameter int TX_DEPTH     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic       tx_serial,
  input  logic       rd_strobe,
  input  logic       wr_strobe,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       flag_di,
  output logic       flag_do,
  input  logic       err_clr,
  output logic       err_frame,
  output logic       err_overrun
);
  localparam int                   CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

  // Two-flop synchroniser plus one history flop for falling-edge detection
  logic sync1_q, sync2_q, rx_prev_q, rx_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each stage capture the previous stage's
      // old value; blocking ones would collapse the chain into a single flop.
      sync1_q   <= rx_serial;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign rx_fall = rx_prev_q & ~sync2_q;

  // ---------------- receiver ----------------
  rx_state_t            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BIT_CNT_W-1:0] rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_done, rx_push, rx_frame_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so branches that leave it alone
    // hold state instead of inferring a latch.
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + BIT_CNT_W'(1);
          if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_done      = (rx_state_q == RX_STOP) && (rx_cnt_q == CNT_LAST);
    rx_push      = rx_done && sync2_q;
    rx_frame_err = rx_done && !sync2_q;
  end

  // ---------------- FIFOs ----------------
  logic [DATA_BITS-1:0] rx_dout, tx_dout;
  logic                 rx_empty, rx_full_unused, rx_ovf;
  logic                 tx_empty, tx_full, tx_ovf, tx_pop;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rx_push),
    .din      (rx_shift_q),
    .pop      (rd_strobe),
    .dout     (rx_dout),
    .empty    (rx_empty),
    .full     (rx_full_unused),
    .overflow (rx_ovf)
  );

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_strobe),
    .din      (wr_data),
    .pop      (tx_pop),
    .dout     (tx_dout),
    .empty    (tx_empty),
    .full     (tx_full),
    .overflow (tx_ovf)
  );

  // ---------------- transmitter ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_CNT_W-1:0] tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_line_q, tx_line_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_pop) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_shift_d = tx_dout;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          tx_bit_d   = tx_bit_q + BIT_CNT_W'(1);
          if (tx_bit_q == BIT_LAST) tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when another byte is waiting
          if (tx_pop) begin
            tx_state_d = TX_START;
            tx_shift_d = tx_dout;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = !tx_empty &&
             ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && (tx_cnt_q == CNT_LAST)));
    tx_line_d = 1'b1;
    unique case (tx_state_d)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = tx_shift_d[0];
      default:  tx_line_d = 1'b1;
    endcase
  end

  // ---------------- sticky errors and bus outputs ----------------
  logic err_frame_q, err_frame_d, err_overrun_q, err_overrun_d;

  always_comb begin
    err_frame_d   = rx_frame_err | (err_frame_q & ~err_clr);
    err_overrun_d = rx_ovf | tx_ovf | (err_overrun_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign tx_serial   = tx_line_q;
  assign rd_data     = rx_empty ? '0 : rx_dout;
  assign flag_di     = ~rx_empty;
  assign flag_do     = ~tx_full;
  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_bus_peripheral.sv
// Self-checking bench for uart_bus_peripheral: fixed TX line-pattern table, serial RX
// frames, an echo loop, randomized FIFO-boundary bursts and framing/glitch cases.
module tb_uart_bus_peripheral;
  localparam int CPB   = 16;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, rx_serial, tx_serial, rd_strobe, wr_strobe, err_clr;
  logic       flag_di, flag_do, err_frame, err_overrun;
  logic [7:0] wr_data, rd_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_bus_peripheral #(.CLKS_PER_BIT(CPB), .RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_serial   (rx_serial),
    .tx_serial   (tx_serial),
    .rd_strobe   (rd_strobe),
    .wr_strobe   (wr_strobe),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .flag_di     (flag_di),
    .flag_do     (flag_do),
    .err_clr     (err_clr),
    .err_frame   (err_frame),
    .err_overrun (err_overrun)
  );

  // Expected line levels in transmit order: bit 0 = start, bits 1..8 = data LSB first, bit 9 = stop
  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } tx_vec_t;
  tx_vec_t tx_vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic cpu_write(input logic [7:0] b);
    wr_strobe = 1'b1;
    wr_data   = b;
    tick();
    wr_strobe = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
    rx_serial = 1'b0;
    ticks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      ticks(CPB);
    end
    rx_serial = stop_bit;
    ticks(CPB);
    rx_serial = 1'b1;
  endtask

  // Waits (bounded) for a start bit on tx_serial and decodes the frame at mid-bit points
  task automatic tx_decode(output logic [7:0] b, output logic ok, output int start_cyc);
    int w;
    w = 0;
    ok = 1'b1;
    b = '0;
    start_cyc = -1;
    while (tx_serial !== 1'b0 && w < 400) begin
      tick();
      w++;
    end
    if (tx_serial !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    start_cyc = cyc;
    ticks(CPB / 2);
    if (tx_serial !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ticks(CPB);
      b[i] = tx_serial;
    end
    ticks(CPB);
    if (tx_serial !== 1'b1) ok = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] sent[3];
    logic [7:0] burst[19];
    logic [7:0] rxb[17];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] b, e;
    logic       ok, m_ovr;
    int         st[3];
    int         w_cyc, sc, m_cnt;

    tx_vecs[0] = '{8'h41, 10'b1_01000001_0};
    tx_vecs[1] = '{8'h55, 10'b1_01010101_0};
    tx_vecs[2] = '{8'h00, 10'b1_00000000_0};
    tx_vecs[3] = '{8'hFF, 10'b1_11111111_0};
    tx_vecs[4] = '{8'hA3, 10'b1_10100011_0};
    sent = '{8'h48, 8'h69, 8'h21};

    reset = 1'b0; rx_serial = 1'b1; rd_strobe = 1'b0; wr_strobe = 1'b0;
    err_clr = 1'b0; wr_data = '0;
    #2 reset = 1'b1;
    ticks(2);
    check("reset tx_serial", tx_serial, 1);
    check("reset rd_data", rd_data, 0);
    check("reset flag_di", flag_di, 0);
    check("reset flag_do", flag_do, 1);
    check("reset err_frame", err_frame, 0);
    check("reset err_overrun", err_overrun, 0);
    reset = 1'b0;
    ticks(3);

    // Reset in the middle of transmitting 0x55 returns the line high at once
    cpu_write(8'h55);
    ticks(40);
    check("tx low mid-frame before reset", tx_serial, 0);
    reset = 1'b1;
    #1;
    check("async reset tx_serial", tx_serial, 1);
    check("async reset flag_do", flag_do, 1);
    check("async reset flag_di", flag_di, 0);
    ticks(3);
    reset = 1'b0;
    ticks(30);
    check("no frame resumes after reset", tx_serial, 1);

    // Table-driven TX line patterns: start from edge N+1, every bit exactly CPB clocks
    for (int v = 0; v < 5; v++) begin
      cpu_write(tx_vecs[v].data);
      check($sformatf("tx %02h idle on write edge", tx_vecs[v].data), tx_serial, 1);
      for (int k = 0; k < 10; k++) begin
        ok = 1'b1;
        for (int c = 0; c < CPB; c++) begin
          tick();
          if (tx_serial !== tx_vecs[v].line[k]) ok = 1'b0;
        end
        check($sformatf("tx %02h bit%0d level", tx_vecs[v].data, k), ok, 1);
      end
    end
    ticks(5);

    // RX of 0xA5: nothing before the stop sample, byte visible once the frame ends
    rx_serial = 1'b0;
    ticks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_serial = e[0];
      e = 8'hA5 >> i;
      rx_serial = e[0];
      ticks(CPB);
    end
    rx_serial = 1'b1;
    ticks(CPB / 2);
    check("rx flag_di before stop sample", flag_di, 0);
    ticks(CPB / 2);
    check("rx flag_di after frame", flag_di, 1);
    check("rx rd_data A5", rd_data, 8'hA5);
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    check("rx flag_di after pop", flag_di, 0);
    check("rx rd_data empty", rd_data, 0);

    // Reset during a partial RX frame discards it
    rx_serial = 1'b0;
    ticks(CPB);
    rx_serial = 1'b1;
    ticks(3 * CPB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ticks(200);
    check("partial rx frame discarded by reset", flag_di, 0);

    // Echo loop: receive "Hi!", pop each byte and write it straight back
    for (int i = 0; i < 3; i++) drive_rx(sent[i], 1'b1);
    ticks(2);
    w_cyc = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          check($sformatf("echo flag_di %0d", i), flag_di, 1);
          check($sformatf("echo rd_data %0d", i), rd_data, sent[i]);
          rd_strobe = 1'b1;
          wr_strobe = 1'b1;
          wr_data   = rd_data;
          tick();
          if (i == 0) w_cyc = cyc;
          rd_strobe = 1'b0;
          wr_strobe = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          tx_decode(b, ok, sc);
          st[k] = sc;
          check($sformatf("echo frame %0d ok", k), ok, 1);
          check($sformatf("echo frame %0d byte", k), b, sent[k]);
        end
      end
    join
    check("echo start latency", st[0] - w_cyc, 1);
    check("echo gap 0-1", st[1] - st[0], 10 * CPB);
    check("echo gap 1-2", st[2] - st[1], 10 * CPB);
    check("echo rx drained", flag_di, 0);
    ticks(CPB);

    // Random TX burst while the transmitter is busy: 16 fit, later writes dropped
    for (int i = 0; i < 19; i++) burst[i] = 8'($urandom_range(0, 255));
    exp_tx.delete();
    exp_tx.push_back(burst[0]);
    for (int i = 1; i < 19; i++) if (i <= DEPTH) exp_tx.push_back(burst[i]);
    fork
      begin
        cpu_write(burst[0]);
        ticks(3);
        m_cnt = 0;
        m_ovr = 1'b0;
        for (int i = 1; i < 19; i++) begin
          wr_strobe = 1'b1;
          wr_data   = burst[i];
          err_clr   = (i == 18);
          tick();
          wr_strobe = 1'b0;
          err_clr   = 1'b0;
          if (m_cnt < DEPTH) m_cnt++;
          else m_ovr = 1'b1;
          check($sformatf("burst flag_do after write %0d", i), flag_do, 32'(m_cnt < DEPTH));
          check($sformatf("burst err_overrun after write %0d", i), err_overrun, 32'(m_ovr));
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("burst err_clr clears overrun", err_overrun, 0);
      end
      begin
        for (int k = 0; exp_tx.size() > 0; k++) begin
          e = exp_tx.pop_front();
          tx_decode(b, ok, sc);
          check($sformatf("burst frame %0d ok", k), ok, 1);
          check($sformatf("burst frame %0d byte", k), b, e);
        end
        tx_decode(b, ok, sc);
        check("no frame for dropped bytes", ok, 0);
      end
    join
    check("burst flag_do after drain", flag_do, 1);

    // Random RX burst of 17 unread bytes: first 16 kept in order, 17th overruns
    exp_rx.delete();
    m_ovr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      rxb[i] = 8'($urandom_range(0, 255));
      drive_rx(rxb[i], 1'b1);
      if (exp_rx.size() < DEPTH) exp_rx.push_back(rxb[i]);
      else m_ovr = 1'b1;
    end
    ticks(4);
    check("rx burst err_overrun", err_overrun, 32'(m_ovr));
    for (int k = 0; exp_rx.size() > 0; k++) begin
      e = exp_rx.pop_front();
      check($sformatf("rx burst flag_di %0d", k), flag_di, 1);
      check($sformatf("rx burst byte %0d", k), rd_data, e);
      rd_strobe = 1'b1;
      tick();
      rd_strobe = 1'b0;
    end
    check("rx burst drained flag_di", flag_di, 0);
    check("rx burst drained rd_data", rd_data, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    check("pop on empty no overrun", err_overrun, 0);
    check("pop on empty flag_di", flag_di, 0);

    // Framing error: 0x3C with a low stop bit is dropped and flagged
    drive_rx(8'h3C, 1'b0);
    ticks(4);
    check("frame err byte not pushed", flag_di, 0);
    check("frame err flag", err_frame, 1);
    check("frame err no overrun", err_overrun, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("frame err cleared", err_frame, 0);

    // Short low glitch is rejected by the start-bit check
    rx_serial = 1'b0;
    ticks(4);
    rx_serial = 1'b1;
    ticks(200);
    check("glitch no byte", flag_di, 0);
    check("glitch no frame err", err_frame, 0);
    check("glitch no overrun", err_overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
